// File: rtl/seq_mul_32.sv
// seq_mul_32: 32x32->64 shift-add multiplier, one multiplier bit per cycle.
// Define SEQ_MUL_SIGNED_EN for two's complement operands (adds a FIXUP cycle).
`timescale 1ns/1ps
module seq_mul_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [5:0]  cnt_q, cnt_d;

  logic [31:0] addend;
  logic [31:0] sum;
  logic        cout;
  logic [31:0] ld_a;
  logic [31:0] ld_b;

  // Same hookup as RCA_32_bit_comb: a=acc_hi, b=gated mcand, cin=0.
  assign addend      = mcand_q & {32{acc_lo_q[0]}};
  assign {cout, sum} = {1'b0, acc_hi_q} + {1'b0, addend};

`ifdef SEQ_MUL_SIGNED_EN
  logic neg_q, neg_d;
  logic [63:0] neg_prod;

  // |-2^31| wraps to 0x80000000, which is correct read as unsigned.
  assign ld_a     = a[31] ? (~a + 32'd1) : a;
  assign ld_b     = b[31] ? (~b + 32'd1) : b;
  assign neg_prod = ~{acc_hi_q, acc_lo_q} + 64'd1;
`else
  assign ld_a = a;
  assign ld_b = b;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
`ifdef SEQ_MUL_SIGNED_EN
    neg_d    = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = ld_a;
          acc_lo_d = ld_b;
          acc_hi_d = '0;
          cnt_d    = '0;
`ifdef SEQ_MUL_SIGNED_EN
          neg_d    = a[31] ^ b[31];
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        {acc_hi_d, acc_lo_d} = {cout, sum, acc_lo_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
`ifdef SEQ_MUL_SIGNED_EN
          state_d = FIXUP;
`else
          state_d = DONE;
`endif
        end
      end
      FIXUP: begin
`ifdef SEQ_MUL_SIGNED_EN
        if (neg_q) {acc_hi_d, acc_lo_d} = neg_prod;
        state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef SEQ_MUL_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end
`endif

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = {acc_hi_q, acc_lo_q};

endmodule
